mspe_core_scheduler: RTL and testbench

Parametrised core-lifecycle scheduler for the multi-core stream PE. It grants free cores to incoming jobs round-robin and tracks each core through load, run and completion. It drives the per-core run bits and reports completions, in completion order, through a ready/valid queue. It replaces the fixed 4-core simple assignment and queue pair between the stream parser, the data loader and the core array.

---
 rtl/mspe_sched_pkg.sv | 26 ++
 rtl/mspe_id_fifo.sv | 78 +++++++
 rtl/mspe_core_scheduler.sv | 232 +++++++++++++++++++++++
 tb/tb_mspe_core_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mspe_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mspe_sched_pkg
// Description : Shared types and helpers for the multi-core stream PE core
//               scheduler: per-core lifecycle state encoding and the core-ID
//               width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mspe_sched_pkg;

    // Per-core lifecycle: FREE -> LOADING -> RUNNING -> HALTED -> QUEUED -> FREE
    typedef enum logic [2:0] {
        FREE    = 3'd0,
        LOADING = 3'd1,
        RUNNING = 3'd2,
        HALTED  = 3'd3,
        QUEUED  = 3'd4
    } core_state_e;

    // Width of a core index; never narrower than one bit.
    function automatic int id_w(input int cores);
        return (cores <= 2) ? 1 : $clog2(cores);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mspe_id_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mspe_id_fifo
// Description : Small synchronous FIFO for completion entries. Registered
//               storage, no fall-through: a push is visible on out_valid the
//               cycle after it is written. Head data is stable while
//               out_ready is low.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               in_valid/in_data - push side (dropped if full)
//               out_valid/out_data/out_ready - pop side, ready/valid
// Revision    : 1.0 - initial release
// ============================================================================
module mspe_id_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    localparam int PTR_W = (DEPTH <= 2) ? 1 : $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign do_pop    = out_valid && out_ready;
    assign do_push   = in_valid && (count_q != CNT_W'(DEPTH));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count_q gates visibility of every entry.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mspe_core_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : mspe_core_scheduler
// Description : Core-lifecycle scheduler for the multi-core stream PE. Grants
//               FREE cores round-robin, tracks each core through load, run
//               and halt, and reports completions in order through a
//               ready/valid queue. A core is only re-grantable once its
//               completion has been popped.
// Ports       : req_valid/req_ready/req_id   - core request and grant
//               load_done/load_id            - loader finished a core image
//               core_halt / core_run         - per-core halt level / run enable
//               done_valid/done_id/done_timeout/done_ready - completion queue
//               timeout_cycles               - watchdog limit (0 = off)
//               busy_mask, err_sticky        - status
// Config      : MSPE_SCHED_WATCHDOG_EN enables per-core run watchdogs.
// Revision    : 1.0 - initial release
// ============================================================================
module mspe_core_scheduler
    import mspe_sched_pkg::*;
#(
    parameter  int CORES     = 4,
    parameter  int TIMEOUT_W = 24,
    localparam int ID_W      = id_w(CORES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    output logic [ID_W-1:0]      req_id,
    input  logic                 load_done,
    input  logic [ID_W-1:0]      load_id,
    input  logic [CORES-1:0]     core_halt,
    output logic [CORES-1:0]     core_run,
    output logic                 done_valid,
    output logic [ID_W-1:0]      done_id,
    output logic                 done_timeout,
    input  logic                 done_ready,
    input  logic [TIMEOUT_W-1:0] timeout_cycles,
    output logic [CORES-1:0]     busy_mask,
    output logic                 err_sticky
);

    core_state_e        state_q [CORES];
    core_state_e        state_d [CORES];
    logic [CORES-1:0]   flag_q, flag_d;          // timeout flag per core
    logic [ID_W-1:0]    last_grant_q, last_grant_d;
    logic [CORES-1:0]   halt_prev_q, halt_prev_d;
    logic [CORES-1:0]   halt_edge_q, halt_edge_d;
    logic               err_q, err_d;

    logic [CORES-1:0]   free_mask;
    logic [CORES-1:0]   wd_expire;
    logic               grant_fire;
    logic               pop_fire;
    logic               push_valid;
    logic [ID_W-1:0]    push_idx;
    logic               push_flag;
    logic [ID_W:0]      fifo_data;
    int                 rr_dist;
    int                 rr_best;

    for (genvar g = 0; g < CORES; g++) begin : g_core
        assign free_mask[g] = (state_q[g] == FREE);
        assign core_run[g]  = (state_q[g] == RUNNING);
    end

    assign busy_mask  = ~free_mask;
    assign req_ready  = |free_mask;
    assign err_sticky = err_q;
    assign grant_fire = req_valid && req_ready;
    assign pop_fire   = done_valid && done_ready;

    // Round-robin: pick the FREE core at the smallest distance past the last
    // grant, so the search starts at last_grant+1 and wraps.
    always_comb begin
        req_id  = '0;
        rr_best = CORES;
        rr_dist = 0;
        for (int i = 0; i < CORES; i++) begin
            rr_dist = i - int'(last_grant_q) - 1;
            if (rr_dist < 0) begin
                rr_dist = rr_dist + CORES;
            end
            if (state_q[i] == FREE && rr_dist < rr_best) begin
                rr_best = rr_dist;
                req_id  = ID_W'(i);
            end
        end
    end

    // Lowest-index HALTED core is pushed into the completion queue.
    always_comb begin
        push_valid = 1'b0;
        push_idx   = '0;
        push_flag  = 1'b0;
        for (int i = CORES - 1; i >= 0; i--) begin
            if (state_q[i] == HALTED) begin
                push_valid = 1'b1;
                push_idx   = ID_W'(i);
                push_flag  = flag_q[i];
            end
        end
    end

    // Halt edges are registered first; the state update consumes the
    // registered edge, giving the two-cycle halt-to-run-low latency.
    assign halt_prev_d = core_halt;
    assign halt_edge_d = core_halt & ~halt_prev_q;

    always_comb begin
        last_grant_d = last_grant_q;
        err_d        = err_q;
        flag_d       = flag_q;
        for (int i = 0; i < CORES; i++) begin
            state_d[i] = state_q[i];
        end
        if (grant_fire) begin
            last_grant_d = req_id;
        end
        for (int i = 0; i < CORES; i++) begin
            case (state_q[i])
                FREE: begin
                    if (grant_fire && int'(req_id) == i) begin
                        state_d[i] = LOADING;
                    end
                end
                LOADING: begin
                    if (load_done && int'(load_id) == i) begin
                        state_d[i] = RUNNING;
                        flag_d[i]  = 1'b0;
                    end
                end
                RUNNING: begin
                    // A real halt beats a coincident watchdog expiry.
                    if (halt_edge_q[i]) begin
                        state_d[i] = HALTED;
                        flag_d[i]  = 1'b0;
                    end else if (wd_expire[i]) begin
                        state_d[i] = HALTED;
                        flag_d[i]  = 1'b1;
                    end
                end
                HALTED: begin
                    if (int'(push_idx) == i) begin
                        state_d[i] = QUEUED;
                    end
                end
                QUEUED: begin
                    if (pop_fire && int'(done_id) == i) begin
                        state_d[i] = FREE;
                    end
                end
                default: begin
                    state_d[i] = FREE;
                end
            endcase
            if (load_done && int'(load_id) == i && state_q[i] != LOADING) begin
                err_d = 1'b1;
            end
            // A halt edge coinciding with this core's load is silently dropped.
            if (halt_edge_q[i] && state_q[i] != RUNNING &&
                !(load_done && int'(load_id) == i && state_q[i] == LOADING)) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CORES; i++) begin
                state_q[i] <= FREE;
            end
            flag_q       <= '0;
            last_grant_q <= ID_W'(CORES - 1);
            halt_prev_q  <= '0;
            halt_edge_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            for (int i = 0; i < CORES; i++) begin
                state_q[i] <= state_d[i];
            end
            flag_q       <= flag_d;
            last_grant_q <= last_grant_d;
            halt_prev_q  <= halt_prev_d;
            halt_edge_q  <= halt_edge_d;
            err_q        <= err_d;
        end
    end

    // Each core owns at most one entry, so DEPTH = CORES never overflows.
    mspe_id_fifo #(
        .DEPTH (CORES),
        .WIDTH (ID_W + 1)
    ) u_done_fifo (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (push_valid),
        .in_data   ({push_flag, push_idx}),
        .out_valid (done_valid),
        .out_data  (fifo_data),
        .out_ready (done_ready)
    );

    assign done_id = fifo_data[ID_W-1:0];

`ifdef MSPE_SCHED_WATCHDOG_EN
    // Counter holds the number of RUNNING cycles already completed; expiry
    // fires at the end of the timeout_cycles-th RUNNING cycle.
    for (genvar g = 0; g < CORES; g++) begin : g_wd
        logic [TIMEOUT_W-1:0] wd_cnt_q;
        logic [TIMEOUT_W-1:0] wd_cnt_d;
        assign wd_cnt_d     = (state_q[g] == RUNNING) ? wd_cnt_q + TIMEOUT_W'(1) : '0;
        assign wd_expire[g] = (state_q[g] == RUNNING) && (timeout_cycles != '0) &&
                              (wd_cnt_d == timeout_cycles);
        always_ff @(posedge clk) begin
            if (reset) begin
                wd_cnt_q <= '0;
            end else begin
                wd_cnt_q <= wd_cnt_d;
            end
        end
    end
    assign done_timeout = fifo_data[ID_W];
`else
    logic unused_cfg;
    assign wd_expire    = '0;
    assign done_timeout = 1'b0;
    assign unused_cfg   = ^{timeout_cycles, fifo_data[ID_W]};
`endif

endmodule
`default_nettype wire

// File: tb/tb_mspe_core_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_mspe_core_scheduler
// Description : Self-checking bench for mspe_core_scheduler. A queue/array
//               model of the core lifecycle is stepped on every clock and
//               compared with the DUT each cycle; directed scenarios add
//               hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mspe_core_scheduler;

    localparam int CORES = 4;
    localparam int TW    = 24;
    localparam int M_FREE = 0, M_LOAD = 1, M_RUN = 2, M_HALT = 3, M_QUEUED = 4;

    logic          clk = 1'b0;
    logic          reset, req_valid, req_ready, load_done;
    logic [1:0]    req_id, load_id, done_id;
    logic [3:0]    core_halt, core_run, busy_mask;
    logic          done_valid, done_timeout, done_ready, err_sticky;
    logic [TW-1:0] timeout_cycles;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mspe_core_scheduler #(.CORES(CORES), .TIMEOUT_W(TW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_id(req_id), .load_done(load_done), .load_id(load_id),
        .core_halt(core_halt), .core_run(core_run), .done_valid(done_valid),
        .done_id(done_id), .done_timeout(done_timeout), .done_ready(done_ready),
        .timeout_cycles(timeout_cycles), .busy_mask(busy_mask), .err_sticky(err_sticky)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  ms    [CORES];
    bit  mflag [CORES];
    int  mruns [CORES];     // RUNNING cycles completed in the current job
    bit  mprev [CORES];
    bit  mpend [CORES];     // halt edge seen, takes effect on the next clock
    int  mlast;
    bit  merr;
    int  mq_id [$];
    bit  mq_to [$];
    bit  model_on = 1'b0;

    function automatic int rr_pick();
        for (int off = 1; off <= CORES; off++) begin
            if (ms[(mlast + off) % CORES] == M_FREE) return (mlast + off) % CORES;
        end
        return -1;
    endfunction

    task automatic model_step();
        int nst [CORES];
        bit nfl [CORES];
        int g, h;
        if (reset) begin
            for (int i = 0; i < CORES; i++) begin
                ms[i] = M_FREE; mflag[i] = 0; mruns[i] = 0; mprev[i] = 0; mpend[i] = 0;
            end
            mlast = CORES - 1;
            merr  = 0;
            mq_id.delete();
            mq_to.delete();
            model_on = 1'b1;
            return;
        end
        for (int i = 0; i < CORES; i++) begin
            nst[i] = ms[i];
            nfl[i] = mflag[i];
        end
        g = rr_pick();
        if (req_valid && g >= 0) begin
            nst[g] = M_LOAD;
            mlast  = g;
        end
        if (load_done) begin
            if (ms[load_id] == M_LOAD) begin
                nst[load_id]   = M_RUN;
                nfl[load_id]   = 0;
                mruns[load_id] = 0;
            end else begin
                merr = 1;
            end
        end
        for (int i = 0; i < CORES; i++) begin
            if (ms[i] == M_RUN) begin
                mruns[i]++;
                if (mpend[i]) begin
                    nst[i] = M_HALT;
                    nfl[i] = 0;
                end
`ifdef MSPE_SCHED_WATCHDOG_EN
                else if (timeout_cycles != 0 && mruns[i] == int'(timeout_cycles)) begin
                    nst[i] = M_HALT;
                    nfl[i] = 1;
                end
`endif
            end else if (mpend[i] && !(load_done && int'(load_id) == i && ms[i] == M_LOAD)) begin
                merr = 1;
            end
        end
        if (mq_id.size() > 0 && done_ready) begin
            nst[mq_id[0]] = M_FREE;
            void'(mq_id.pop_front());
            void'(mq_to.pop_front());
        end
        h = -1;
        for (int i = CORES - 1; i >= 0; i--) if (ms[i] == M_HALT) h = i;
        if (h >= 0) begin
            nst[h] = M_QUEUED;
            mq_id.push_back(h);
            mq_to.push_back(mflag[h]);
        end
        for (int i = 0; i < CORES; i++) begin
            mpend[i] = core_halt[i] && !mprev[i];
            mprev[i] = core_halt[i];
            ms[i]    = nst[i];
            mflag[i] = nfl[i];
        end
    endtask

    task automatic model_compare();
        logic [3:0] er, eb;
        int g;
        er = '0;
        eb = '0;
        for (int i = 0; i < CORES; i++) begin
            er[i] = (ms[i] == M_RUN);
            eb[i] = (ms[i] != M_FREE);
        end
        g = rr_pick();
        check("m_req_ready", req_ready, (g >= 0));
        if (g >= 0) check("m_req_id", req_id, g);
        check("m_core_run", core_run, er);
        check("m_busy_mask", busy_mask, eb);
        check("m_done_valid", done_valid, (mq_id.size() > 0));
        if (mq_id.size() > 0) begin
            check("m_done_id", done_id, mq_id[0]);
            check("m_done_timeout", done_timeout, mq_to[0]);
        end
        check("m_err_sticky", err_sticky, merr);
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        if (model_on) model_compare();
    end

    // ---------------- directed stimulus ----------------
    int ids [$];
    int pos [$];
    int run_cnt;

    initial begin
        reset = 1; req_valid = 0; load_done = 0; load_id = 0;
        core_halt = 0; done_ready = 0; timeout_cycles = 0;
        repeat (3) @(negedge clk);
        reset = 0;
        check("rst_req_ready", req_ready, 1);
        check("rst_busy", busy_mask, 4'h0);
        check("rst_done_valid", done_valid, 0);
        check("rst_done_timeout", done_timeout, 0);
        check("rst_core_run", core_run, 4'h0);
        check("rst_err", err_sticky, 0);

        // Five cycles of requests: grants 0..3 then no core left.
        req_valid = 1;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) begin
                check("grant_ready", req_ready, 1);
                check("grant_id", req_id, k);
            end else begin
                check("full_ready_low", req_ready, 0);
            end
            @(negedge clk);
        end
        req_valid = 0;
        check("busy_full", busy_mask, 4'hF);

        load_done = 1; load_id = 2;
        @(negedge clk);
        load_done = 0;
        check("run_after_load2", core_run, 4'b0100);
        load_done = 1; load_id = 1;
        @(negedge clk);
        load_id = 3;
        @(negedge clk);
        load_done = 0;
        check("run_123", core_run, 4'b1110);

        // Cores 1 and 3 halt together; completions drain in index order.
        done_ready = 1;
        core_halt  = 4'b1010;
        @(negedge clk);
        check("halt_run_1cyc", core_run, 4'b1110);
        @(negedge clk);
        check("halt_run_2cyc", core_run, 4'b0100);
        for (int c = 0; c < 12; c++) begin
            if (done_valid) begin
                ids.push_back(done_id);
                pos.push_back(c);
            end
            @(negedge clk);
        end
        core_halt = 0;
        check("pop_count", ids.size(), 2);
        if (ids.size() == 2) begin
            check("pop_first_id", ids[0], 1);
            check("pop_second_id", ids[1], 3);
            check("pop_consecutive", pos[1] - pos[0], 1);
        end
        check("busy_after_pops", busy_mask, 4'b0101);

        // Re-grant 1 and 3, then hold the completion of core 1.
        req_valid = 1;
        check("regrant_1", req_id, 1);
        @(negedge clk);
        check("regrant_3", req_id, 3);
        @(negedge clk);
        req_valid = 0;
        load_done = 1; load_id = 1;
        @(negedge clk);
        load_done  = 0;
        done_ready = 0;
        core_halt  = 4'b0010;
        repeat (4) @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            check("held_valid", done_valid, 1);
            check("held_id", done_id, 1);
            check("held_ready_low", req_ready, 0);
            @(negedge clk);
        end
        core_halt  = 0;
        done_ready = 1;
        @(negedge clk);
        done_ready = 0;
        check("ready_after_pop", req_ready, 1);
        check("next_grant_1", req_id, 1);

        // Protocol errors: load for a FREE core, halt for a LOADING core.
        check("err_clear", err_sticky, 0);
        load_done = 1; load_id = 1;
        @(negedge clk);
        load_done = 0;
        check("err_load_free", err_sticky, 1);
        check("busy_unchanged", busy_mask, 4'b1101);
        core_halt = 4'b0001;
        repeat (3) @(negedge clk);
        core_halt = 0;
        check("halt_loading_busy", busy_mask, 4'b1101);
        check("halt_loading_run", core_run, 4'b0100);
        check("err_held", err_sticky, 1);

        // Reset mid-operation drops every run bit.
        reset = 1;
        @(negedge clk);
        reset = 0;
        check("midrst_run", core_run, 4'h0);
        check("midrst_busy", busy_mask, 4'h0);
        check("midrst_err", err_sticky, 0);

`ifdef MSPE_SCHED_WATCHDOG_EN
        timeout_cycles = 10;
        req_valid = 1;
        check("wd_grant0", req_id, 0);
        @(negedge clk);
        req_valid = 0;
        load_done = 1; load_id = 0;
        @(negedge clk);
        load_done = 0;
        run_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (core_run[0]) run_cnt++;
            @(negedge clk);
        end
        check("wd_run_cycles", run_cnt, 10);
        check("wd_done_valid", done_valid, 1);
        check("wd_done_id", done_id, 0);
        check("wd_done_timeout", done_timeout, 1);
        done_ready = 1;
        @(negedge clk);
        done_ready = 0;
        timeout_cycles = 0;
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL global_timeout: simulation did not finish, got %0d errors", errors);
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire
